// File: rtl/picomips_host_pkg.sv
// picomips_host_pkg
// Shared types and constants for the host-side driver of the picoMips
// switch/LED interface.
//   state_t      : driver FSM states
//   SW_NRESET    : SW bit that drives the CPU nReset
//   SW_HS        : SW bit that drives the Handshake line
//   SW_DATA_MSB  : top bit of the operand byte on SW
//   byte_t       : signed byte as seen on the LED accumulator
//   max_of       : helper for sizing the shared phase timer
package picomips_host_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SETUP,
        HS_HIGH,
        HS_LOW,
        WAIT_RESULT,
        EMIT
    } state_t;

    localparam int SW_NRESET   = 9;
    localparam int SW_HS       = 8;
    localparam int SW_DATA_MSB = 7;

    typedef logic signed [7:0] byte_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sw_host_driver_hs_timer.sv
// hs_timer
// Down-counter that times every phase of the switch driver. A load writes a
// new terminal count; otherwise the counter decrements and parks at zero.
//   Clock      : system clock
//   nReset     : synchronous active-low reset, loads RESET_VALUE
//   load       : load load_value this cycle (has priority over counting)
//   load_value : value to load
//   zero       : counter currently at zero (last cycle of a phase)
module hs_timer #(
    parameter int                WIDTH       = 5,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Reset preloads the first phase so the driver starts timing at once;
    // the counter stops at zero so idle states see a steady zero flag.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sw_host_driver.sv
// sw_host_driver
// Host-side replacement for hand-toggled switches on the picoMips board.
// Operand bytes arrive on a valid/ready stream and are presented on SW[7:0]
// with a timed Handshake pulse on SW[8]; after OPS_PER_RESULT operands the
// LED accumulator is sampled and returned on a valid/ready result stream.
// SW[9] holds the CPU in reset for BOOT_CYCLES after every driver reset.
//   Clock     : system clock
//   nReset    : synchronous active-low reset
//   in_valid  : operand byte available
//   in_data   : operand byte
//   in_ready  : driver accepts an operand this cycle
//   out_valid : result byte available
//   out_data  : sampled LED value
//   out_ready : consumer accepts the result
//   SW        : to picoMips SW ([9] CPU nReset, [8] Handshake, [7:0] data)
//   LED       : from picoMips LED (accumulator)
//   busy      : high in every state except IDLE
module sw_host_driver
    import picomips_host_pkg::*;
#(
    parameter int BOOT_CYCLES    = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int HOLD_CYCLES    = 8,
    parameter int LOW_CYCLES     = 8,
    parameter int OPS_PER_RESULT = 2,
    parameter int RESULT_DELAY   = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic signed [7:0] out_data,
    input  logic              out_ready,
    output logic [9:0]        SW,
    input  logic signed [7:0] LED,
    output logic              busy
);

    localparam int MAX_PARAM = max_of(max_of(max_of(BOOT_CYCLES, SETUP_CYCLES),
                                             max_of(HOLD_CYCLES, LOW_CYCLES)),
                                      RESULT_DELAY);
    localparam int TIMER_W = $clog2(MAX_PARAM) + 1;
    localparam int OP_W    = $clog2(OPS_PER_RESULT) + 1;

    localparam logic [TIMER_W-1:0] BOOT_LOAD   = TIMER_W'(BOOT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(SETUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOW_LOAD    = TIMER_W'(LOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESULT_LOAD = TIMER_W'(RESULT_DELAY - 1);
    localparam logic [OP_W-1:0]    LAST_OP     = OP_W'(OPS_PER_RESULT - 1);

    // A zero-length phase would collapse the handshake timing, so refuse it.
    if (BOOT_CYCLES < 1 || SETUP_CYCLES < 1 || HOLD_CYCLES < 1 ||
        LOW_CYCLES < 1 || OPS_PER_RESULT < 1 || RESULT_DELAY < 1) begin : g_bad_params
        $error("sw_host_driver: every cycle/count parameter must be at least 1");
    end

    state_t             state;
    logic [OP_W-1:0]    op_count;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;
    logic               accept;
    logic               last_op;

    assign accept  = in_valid && in_ready;
    assign last_op = (op_count == LAST_OP);

    hs_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (BOOT_LOAD)
    ) u_timer (
        .Clock      (Clock),
        .nReset     (nReset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Each phase transition reloads the shared timer with the length of the
    // phase being entered; BOOT's length comes from the timer's reset value.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                end
            end
            HS_HIGH: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = LOW_LOAD;
                end
            end
            HS_LOW: begin
                if (timer_zero && last_op) begin
                    timer_load  = 1'b1;
                    timer_value = RESULT_LOAD;
                end
            end
            default: begin
            end
        endcase
    end

    // Main sequencer. SW, the stream flags and busy are all registered so the
    // board sees clean edges; SW[7:0] is only rewritten on acceptance in IDLE,
    // which keeps the data byte frozen for the whole Handshake pulse.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state     <= BOOT;
            SW        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b1;
            op_count  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (timer_zero) begin
                        SW[SW_NRESET] <= 1'b1;
                        in_ready      <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        SW[SW_DATA_MSB:0] <= in_data;
                        in_ready          <= 1'b0;
                        busy              <= 1'b1;
                        state             <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_zero) begin
                        SW[SW_HS] <= 1'b1;
                        state     <= HS_HIGH;
                    end
                end
                HS_HIGH: begin
                    if (timer_zero) begin
                        SW[SW_HS] <= 1'b0;
                        state     <= HS_LOW;
                    end
                end
                HS_LOW: begin
                    if (timer_zero) begin
                        if (last_op) begin
                            op_count <= '0;
                            state    <= WAIT_RESULT;
                        end else begin
                            op_count <= op_count + OP_W'(1);
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                WAIT_RESULT: begin
                    if (timer_zero) begin
                        out_data  <= LED;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
